// File: rtl/sample_rom_scheduler.sv
// Shares one drum-sample ROM between four voices: one read per voice per sample
// tick, results committed to the mixer together, plus per-voice playback state.
module sample_rom_scheduler #(
    parameter int OFS_W      = 12,
    parameter int SAMPLE_LEN = 4000,
    parameter int ROM_LAT    = 2,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  sample_tick,
    input  logic [3:0]            trig,
    output logic                  rom_rd,
    output logic [OFS_W+1:0]      rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic [4*DATA_W-1:0]   voice_out,
    output logic                  out_valid,
    output logic [3:0]            active,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

    localparam logic [OFS_W-1:0] LAST_OFS   = OFS_W'(SAMPLE_LEN - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'(ROM_LAT - 1);

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [3:0]             pending_q, pending_d;
    logic [3:0]             active_q, active_d;
    logic [3:0]             last_q, last_d;
    logic [OFS_W-1:0]       ofs_q [4];
    logic [OFS_W-1:0]       ofs_d [4];
    logic [DATA_W-1:0]      stg_q [4];
    logic [DATA_W-1:0]      stg_d [4];
    logic [ROM_LAT-1:0]     pv_q, pv_d;
    logic [1:0]             pvc_q [ROM_LAT];
    logic [1:0]             pvc_d [ROM_LAT];
    logic                   rom_rd_q, rom_rd_d;
    logic [OFS_W+1:0]       rom_addr_q, rom_addr_d;
    logic [4*DATA_W-1:0]    voice_out_q, voice_out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   iss_en_s;
    logic [1:0]             iv_s;

    // Next-state logic: FSM, voice bookkeeping, read issue and data capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        active_d    = active_q;
        last_d      = last_q;
        ofs_d       = ofs_q;
        stg_d       = stg_q;
        voice_out_d = voice_out_q;
        overrun_d   = overrun_q;
        out_valid_d = 1'b0;
        rom_rd_d    = 1'b0;
        rom_addr_d  = '0;
        iss_en_s    = 1'b0;
        iv_s        = 2'd0;

        // Read-return tracker: stage 0 mirrors the registered read strobe.
        pv_d[0]  = rom_rd_q;
        pvc_d[0] = rom_addr_q[OFS_W+1:OFS_W];
        for (int j = 1; j < ROM_LAT; j++) begin
            pv_d[j]  = pv_q[j-1];
            pvc_d[j] = pvc_q[j-1];
        end
        if (pv_q[ROM_LAT-1]) begin
            stg_d[pvc_q[ROM_LAT-1]] = rom_data;
        end else begin
            stg_d = stg_q;
        end

        if (play) begin
            pending_d = pending_q | trig;
            if (sample_tick && (state_q != IDLE)) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            IDLE: begin
                if (play && sample_tick) begin
                    for (int v = 0; v < 4; v++) begin
                        if (pending_d[v]) begin
                            active_d[v] = 1'b1;
                            ofs_d[v]    = '0;
                        end else begin
                            active_d[v] = active_q[v];
                        end
                    end
                    pending_d = 4'b0000;
                    state_d   = ISSUE;
                    cnt_d     = 2'd0;
                    iss_en_s  = 1'b1;
                    iv_s      = 2'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (cnt_q == 2'd3) begin
                    state_d = DRAIN;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d    = cnt_q + 2'd1;
                    iss_en_s = 1'b1;
                    iv_s     = cnt_q + 2'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d     = COMMIT;
                    cnt_d       = 2'd0;
                    out_valid_d = 1'b1;
                    active_d    = active_q & ~last_q;
                    for (int v = 0; v < 4; v++) begin
                        voice_out_d[v*DATA_W +: DATA_W] = stg_d[v];
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        // The offset that reaches SAMPLE_LEN-1 is read once more and then frozen.
        if (iss_en_s) begin
            if (active_d[iv_s]) begin
                rom_rd_d       = 1'b1;
                rom_addr_d     = {iv_s, ofs_d[iv_s]};
                last_d[iv_s]   = (ofs_d[iv_s] == LAST_OFS);
                if (ofs_d[iv_s] != LAST_OFS) begin
                    ofs_d[iv_s] = ofs_d[iv_s] + OFS_W'(1);
                end else begin
                    ofs_d[iv_s] = ofs_d[iv_s];
                end
            end else begin
                last_d[iv_s] = 1'b0;
                stg_d[iv_s]  = '0;
            end
        end else begin
            rom_rd_d = 1'b0;
        end

        // Stopping playback abandons the round and silences every voice.
        if (!play) begin
            state_d     = IDLE;
            cnt_d       = 2'd0;
            pending_d   = 4'b0000;
            active_d    = 4'b0000;
            last_d      = 4'b0000;
            pv_d        = '0;
            voice_out_d = '0;
            out_valid_d = 1'b0;
            rom_rd_d    = 1'b0;
            rom_addr_d  = '0;
            for (int v = 0; v < 4; v++) begin
                ofs_d[v] = '0;
                stg_d[v] = '0;
            end
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            pending_q   <= 4'b0000;
            active_q    <= 4'b0000;
            last_q      <= 4'b0000;
            pv_q        <= '0;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            voice_out_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int v = 0; v < 4; v++) begin
                ofs_q[v] <= '0;
                stg_q[v] <= '0;
            end
            for (int j = 0; j < ROM_LAT; j++) begin
                pvc_q[j] <= 2'd0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
            last_q      <= last_d;
            pv_q        <= pv_d;
            rom_rd_q    <= rom_rd_d;
            rom_addr_q  <= rom_addr_d;
            voice_out_q <= voice_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            for (int v = 0; v < 4; v++) begin
                ofs_q[v] <= ofs_d[v];
                stg_q[v] <= stg_d[v];
            end
            for (int j = 0; j < ROM_LAT; j++) begin
                pvc_q[j] <= pvc_d[j];
            end
        end
    end

    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;
    assign voice_out = voice_out_q;
    assign out_valid = out_valid_q;
    assign active    = active_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sample_rom_scheduler.sv
// Scoreboard bench: a round-level model predicts ROM reads and mixer commits.
module tb_sample_rom_scheduler;

    localparam int OFS_W = 12;
    localparam int LEN   = 120;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        sample_tick = 1'b0;
    logic [3:0]  trig = 4'b0000;
    logic        rom_rd;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic [31:0] voice_out;
    logic        out_valid;
    logic [3:0]  active;
    logic        busy;
    logic        overrun;

    sample_rom_scheduler #(.OFS_W(OFS_W), .SAMPLE_LEN(LEN), .ROM_LAT(LAT), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .play(play), .sample_tick(sample_tick), .trig(trig),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .voice_out(voice_out), .out_valid(out_valid), .active(active),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // ROM model: word = low 8 bits of address, two cycles after the read strobe.
    logic [7:0] d1, d2;
    logic       v1, v2;
    always @(posedge clk) begin
        d1 <= rom_addr[7:0];
        v1 <= rom_rd;
        d2 <= d1;
        v2 <= v1;
    end
    assign rom_data = v2 ? d2 : 8'hA5;

    typedef struct { int c; logic [13:0] a; } rd_t;
    typedef struct { int c; logic [31:0] vo; logic [3:0] act; } out_t;
    rd_t  rdq[$];
    out_t outq[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int free_at = 0;
    int kill_chk = -1;
    logic [3:0]  m_pend = 4'b0000;
    logic [3:0]  m_act  = 4'b0000;
    logic [11:0] m_ofs [4];
    logic        m_ovr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        rd_t  r;
        out_t o;
        check_eq("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        check_eq("busy", {31'd0, busy}, {31'd0, (cyc < free_at)});
        if (rom_rd) begin
            if (rdq.size() == 0) begin
                check_eq("rd_spurious", 32'd1, 32'd0);
            end else begin
                r = rdq.pop_front();
                check_eq("rd_cycle", cyc, r.c);
                check_eq("rd_addr", {18'd0, rom_addr}, {18'd0, r.a});
            end
        end else if (rdq.size() > 0 && rdq[0].c <= cyc) begin
            r = rdq.pop_front();
            check_eq("rd_missing", 32'd0, 32'd1);
        end
        if (out_valid) begin
            if (outq.size() == 0) begin
                check_eq("out_spurious", 32'd1, 32'd0);
            end else begin
                o = outq.pop_front();
                check_eq("out_cycle", cyc, o.c);
                check_eq("voice_out", voice_out, o.vo);
                check_eq("active_commit", {28'd0, active}, {28'd0, o.act});
            end
        end else if (outq.size() > 0 && outq[0].c <= cyc) begin
            o = outq.pop_front();
            check_eq("out_missing", 32'd0, 32'd1);
        end
        if (cyc == kill_chk) begin
            check_eq("kill_active", {28'd0, active}, 32'd0);
            check_eq("kill_voice_out", voice_out, 32'd0);
            check_eq("kill_out_valid", {31'd0, out_valid}, 32'd0);
            check_eq("kill_rom_rd", {31'd0, rom_rd}, 32'd0);
        end
    endtask

    task automatic model(input logic r, input logic p, input logic tk, input logic [3:0] tg);
        logic [31:0] vo;
        logic [3:0]  last;
        if (r || !p) begin
            m_pend = 4'b0000;
            m_act  = 4'b0000;
            for (int v = 0; v < 4; v++) m_ofs[v] = 12'd0;
            if (r) m_ovr = 1'b0;
            free_at  = cyc + 1;
            kill_chk = cyc + 1;
            while (rdq.size() > 0 && rdq[$].c > cyc) rdq.pop_back();
            while (outq.size() > 0 && outq[$].c > cyc) outq.pop_back();
        end else begin
            m_pend = m_pend | tg;
            if (tk && cyc < free_at) begin
                m_ovr = 1'b1;
            end else if (tk) begin
                vo   = 32'd0;
                last = 4'b0000;
                for (int v = 0; v < 4; v++) begin
                    if (m_pend[v]) begin
                        m_act[v] = 1'b1;
                        m_ofs[v] = 12'd0;
                    end
                end
                m_pend = 4'b0000;
                for (int v = 0; v < 4; v++) begin
                    if (m_act[v]) begin
                        rdq.push_back('{cyc + 1 + v, {2'(v), m_ofs[v]}});
                        vo[v*8 +: 8] = m_ofs[v][7:0];
                        if (m_ofs[v] == 12'(LEN - 1)) last[v] = 1'b1;
                        else m_ofs[v] = m_ofs[v] + 12'd1;
                    end
                end
                m_act = m_act & ~last;
                outq.push_back('{cyc + 5 + LAT, vo, m_act});
                free_at = cyc + 6 + LAT;
            end
        end
    endtask

    task automatic cyc_step(input logic r, input logic p, input logic tk, input logic [3:0] tg);
        @(negedge clk);
        if (cyc > 0) monitor();
        model(r, p, tk, tg);
        reset = r;
        play = p;
        sample_tick = tk;
        trig = tg;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_step(1'b0, 1'b1, 1'b0, 4'b0000);
    endtask

    initial begin
        for (int v = 0; v < 4; v++) m_ofs[v] = 12'd0;
        for (int i = 0; i < 3; i++) cyc_step(1'b1, 1'b0, 1'b0, 4'b0000);
        idle(2);

        // single voice start, then its second sample
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0001); idle(9);
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0000); idle(9);

        // all voices, two rounds
        cyc_step(1'b0, 1'b1, 1'b1, 4'b1111); idle(9);
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0000); idle(9);

        // long run: v1 retriggered (twice) mid-round at offset 100, others run to the end
        for (int r = 0; r < 120; r++) begin
            cyc_step(1'b0, 1'b1, 1'b1, 4'b0000);
            cyc_step(1'b0, 1'b1, 1'b0, (r == 98) ? 4'b0010 : 4'b0000);
            cyc_step(1'b0, 1'b1, 1'b0, (r == 98) ? 4'b0010 : 4'b0000);
            idle(7);
        end
        check_eq("active_end", {28'd0, active}, 32'h2);

        // tick while busy is dropped and flagged
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0000); idle(2);
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0000); idle(9);
        check_eq("overrun_sticky", {31'd0, overrun}, 32'd1);

        // play low mid-round, then ticks/trigs ignored while stopped
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0001); idle(2);
        cyc_step(1'b0, 1'b0, 1'b0, 4'b0000);
        cyc_step(1'b0, 1'b0, 1'b1, 4'b1111);
        idle(2);
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0000); idle(9);

        // restart after stop, then reset mid-round
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0101); idle(9);
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0100); idle(2);
        cyc_step(1'b1, 1'b1, 1'b0, 4'b0000);
        idle(3);
        cyc_step(1'b0, 1'b1, 1'b1, 4'b1000); idle(9);
        cyc_step(1'b0, 1'b1, 1'b1, 4'b0000); idle(9);

        check_eq("rd_queue_empty", rdq.size(), 32'd0);
        check_eq("out_queue_empty", outq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
